ptring_link_arbiter: RTL and testbench

//  Output-link arbiter for a PtRing station. Shares one ring output link between NUM_REQ two-entry

---
 rtl/ptring_arb_pkg.sv | 16 +
 rtl/ptring_rr_pick.sv | 43 ++++
 rtl/ptring_link_arbiter.sv | 174 +++++++++++++++++
 tb/tb_ptring_link_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ptring_arb_pkg.sv
// Shared types and sizing helpers for the PtRing output-link arbiter.
package ptring_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } arb_state_e;

    localparam int STAT_W = 16;

    // Counter width able to hold 0..credits inclusive.
    function automatic int crd_w(input int credits);
        return $clog2(credits + 1);
    endfunction

endpackage

// File: rtl/ptring_rr_pick.sv
// Combinational rotating-priority picker: the first set request at or after i_ptr wins.
module ptring_rr_pick
    import ptring_arb_pkg::*;
#(
    parameter int NUM_REQ = 3,
    localparam int IDX_W  = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_any
);

    logic [IDX_W:0]   w_sum;
    logic [IDX_W-1:0] w_cand;

    // Scan from the far end back towards i_ptr so the last hit is the nearest one.
    always_comb begin
        o_idx  = '0;
        w_sum  = '0;
        w_cand = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_sum = {1'b0, i_ptr} + (IDX_W + 1)'(k);
            if (w_sum >= (IDX_W + 1)'(NUM_REQ)) begin
                w_sum = w_sum - (IDX_W + 1)'(NUM_REQ);
            end
            w_cand = w_sum[IDX_W-1:0];
            if (i_req[w_cand]) begin
                o_idx = w_cand;
            end
        end
    end

    assign o_any = |i_req;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_gnt
            assign o_gnt[gi] = o_any && (o_idx == IDX_W'(gi));
        end
    endgenerate

endmodule

// File: rtl/ptring_link_arbiter.sv
// PtRing station output-link arbiter: round-robin whole-packet grant, credit gating, registered link.
// Optional per-requester packet counters on oGrantCnt when PTRING_ARB_STATS_EN is defined.
module ptring_link_arbiter
    import ptring_arb_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int NUM_REQ = 3,
    parameter int CREDITS = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              iReqVld,
    input  logic [NUM_REQ-1:0][WIDTH-1:0]   iReqDat,
    input  logic [NUM_REQ-1:0]              iReqLast,
    output logic [NUM_REQ-1:0]              oReqRd,
    output logic                            oLinkVld,
    output logic [WIDTH-1:0]                oLinkDat,
    output logic                            oLinkLast,
    input  logic                            iCrdRet,
    output logic                            oBusy,
    output logic                            oCrdOvf
`ifdef PTRING_ARB_STATS_EN
    ,
    output logic [NUM_REQ-1:0][STAT_W-1:0]  oGrantCnt
`endif
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CRD_W = crd_w(CREDITS);
    localparam logic [CRD_W-1:0] CRD_INIT = CRD_W'(CREDITS);

    function automatic logic [IDX_W-1:0] rr_inc(input logic [IDX_W-1:0] idx);
        if (idx == IDX_W'(NUM_REQ - 1)) begin
            return '0;
        end
        return idx + IDX_W'(1);
    endfunction

    arb_state_e       r_state;
    arb_state_e       w_state_next;
    logic [IDX_W-1:0] r_rr_ptr;
    logic [IDX_W-1:0] w_rr_next;
    logic [IDX_W-1:0] r_owner;
    logic [IDX_W-1:0] w_owner_next;
    logic [CRD_W-1:0] r_crd_cnt;
    logic             r_crd_ovf;
    logic             r_link_vld;
    logic [WIDTH-1:0] r_link_dat;
    logic             r_link_last;

    logic [NUM_REQ-1:0] w_pick_gnt;
    logic [IDX_W-1:0]   w_pick_idx;
    logic               w_pick_any;
    logic               w_send_ok;
    logic               w_pop;
    logic [IDX_W-1:0]   w_pop_idx;

    ptring_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .i_req (iReqVld),
        .i_ptr (r_rr_ptr),
        .o_gnt (w_pick_gnt),
        .o_idx (w_pick_idx),
        .o_any (w_pick_any)
    );

    // A credit returned this cycle only becomes spendable once it lands in r_crd_cnt.
    assign w_send_ok = (r_crd_cnt != '0);

    always_comb begin
        w_state_next = r_state;
        w_rr_next    = r_rr_ptr;
        w_owner_next = r_owner;
        w_pop        = 1'b0;
        w_pop_idx    = r_owner;
        oReqRd       = '0;
        case (r_state)
            IDLE: begin
                if (w_pick_any && w_send_ok) begin
                    w_pop     = 1'b1;
                    w_pop_idx = w_pick_idx;
                    oReqRd    = w_pick_gnt;
                    if (iReqLast[w_pick_idx]) begin
                        w_rr_next = rr_inc(w_pick_idx);
                    end else begin
                        w_state_next = LOCK;
                        w_owner_next = w_pick_idx;
                    end
                end
            end
            LOCK: begin
                // Owner running dry mid-packet leaves a bubble; the lock is kept.
                if (iReqVld[r_owner] && w_send_ok) begin
                    w_pop           = 1'b1;
                    oReqRd[r_owner] = 1'b1;
                    if (iReqLast[r_owner]) begin
                        w_state_next = IDLE;
                        w_rr_next    = rr_inc(r_owner);
                    end
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_rr_ptr <= '0;
            r_owner  <= '0;
        end else begin
            r_state  <= w_state_next;
            r_rr_ptr <= w_rr_next;
            r_owner  <= w_owner_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_crd_cnt <= CRD_INIT;
            r_crd_ovf <= 1'b0;
        end else if (w_pop && !iCrdRet) begin
            r_crd_cnt <= r_crd_cnt - CRD_W'(1);
        end else if (!w_pop && iCrdRet) begin
            if (r_crd_cnt == CRD_INIT) begin
                r_crd_ovf <= 1'b1;
            end else begin
                r_crd_cnt <= r_crd_cnt + CRD_W'(1);
            end
        end
    end

    // Data and tail flag hold their last value while the link is idle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_link_vld  <= 1'b0;
            r_link_dat  <= '0;
            r_link_last <= 1'b0;
        end else begin
            r_link_vld <= w_pop;
            if (w_pop) begin
                r_link_dat  <= iReqDat[w_pop_idx];
                r_link_last <= iReqLast[w_pop_idx];
            end
        end
    end

    assign oLinkVld  = r_link_vld;
    assign oLinkDat  = r_link_dat;
    assign oLinkLast = r_link_last;
    assign oBusy     = (r_state == LOCK);
    assign oCrdOvf   = r_crd_ovf;

`ifdef PTRING_ARB_STATS_EN
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_stats
            logic [STAT_W-1:0] r_grant_cnt;
            always_ff @(posedge clk) begin
                if (!rst) begin
                    r_grant_cnt <= '0;
                end else if (w_pop && (w_pop_idx == IDX_W'(gi)) && iReqLast[gi]
                             && (r_grant_cnt != {STAT_W{1'b1}})) begin
                    r_grant_cnt <= r_grant_cnt + STAT_W'(1);
                end
            end
            assign oGrantCnt[gi] = r_grant_cnt;
        end
    endgenerate
`endif

endmodule

// File: tb/tb_ptring_link_arbiter.sv
// Scoreboard bench for ptring_link_arbiter: a behavioural model predicts pops; popped flits queue for link checks.
module tb_ptring_link_arbiter;
    import ptring_arb_pkg::*;

    localparam int WIDTH   = 32;
    localparam int NUM_REQ = 3;
    localparam int CREDITS = 2;

    logic                          clk = 1'b0;
    logic                          rst = 1'b0;
    logic [NUM_REQ-1:0]            iReqVld = '0;
    logic [NUM_REQ-1:0][WIDTH-1:0] iReqDat = '0;
    logic [NUM_REQ-1:0]            iReqLast = '0;
    logic [NUM_REQ-1:0]            oReqRd;
    logic                          oLinkVld;
    logic [WIDTH-1:0]              oLinkDat;
    logic                          oLinkLast;
    logic                          iCrdRet = 1'b0;
    logic                          oBusy;
    logic                          oCrdOvf;
`ifdef PTRING_ARB_STATS_EN
    logic [NUM_REQ-1:0][STAT_W-1:0] oGrantCnt;
`endif

    ptring_link_arbiter #(
        .WIDTH   (WIDTH),
        .NUM_REQ (NUM_REQ),
        .CREDITS (CREDITS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .iReqVld   (iReqVld),
        .iReqDat   (iReqDat),
        .iReqLast  (iReqLast),
        .oReqRd    (oReqRd),
        .oLinkVld  (oLinkVld),
        .oLinkDat  (oLinkDat),
        .oLinkLast (oLinkLast),
        .iCrdRet   (iCrdRet),
        .oBusy     (oBusy),
        .oCrdOvf   (oCrdOvf)
`ifdef PTRING_ARB_STATS_EN
        ,
        .oGrantCnt (oGrantCnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Source FIFOs ({last, data}) and link scoreboard
    logic [WIDTH:0] fq[NUM_REQ][$];
    logic [WIDTH:0] sb[$];
    int seq = 0;

    // Reference model state
    int             m_state;
    int             m_rr;
    int             m_owner;
    int             m_crd;
    bit             m_ovf;
    bit             m_link_vld;
    logic [WIDTH-1:0] m_dat;
    logic           m_last;
    int             m_gcnt[NUM_REQ];

    logic [NUM_REQ-1:0] last_rd;
    logic               last_busy;
    logic               last_vld;
    int                 dut_pops;

    task automatic push_flit(input int r, input bit last);
        logic [WIDTH-1:0] d;
        d = {8'hA5, 8'(r), 16'(seq)};
        seq++;
        fq[r].push_back({last, d});
    endtask

    task automatic push_pkt(input int r, input int len);
        for (int j = 0; j < len; j++) begin
            push_flit(r, (j == len - 1));
        end
    endtask

    task automatic model_reset();
        m_state    = 0;
        m_rr       = 0;
        m_owner    = 0;
        m_crd      = CREDITS;
        m_ovf      = 0;
        m_link_vld = 0;
        m_dat      = '0;
        m_last     = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) m_gcnt[i] = 0;
    endtask

    task automatic do_reset();
        rst     = 1'b0;
        iReqVld = '0;
        iCrdRet = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) fq[i].delete();
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
        check_eq("rst_link_vld", 32'(oLinkVld), 32'd0);
        check_eq("rst_link_dat", oLinkDat, 32'd0);
        check_eq("rst_link_last", 32'(oLinkLast), 32'd0);
        check_eq("rst_busy", 32'(oBusy), 32'd0);
        check_eq("rst_ovf", 32'(oCrdOvf), 32'd0);
    endtask

    // ret_mode: 0 no return, 1 one return pulse, 2 return mirrors the flit on the link
    task automatic step(input int ret_mode);
        bit               ret;
        bit               pop;
        bit               found;
        bit               plast;
        int               pidx;
        logic [WIDTH:0]   head;
        logic [WIDTH:0]   item;
        logic [NUM_REQ-1:0] exp_rd;

        for (int i = 0; i < NUM_REQ; i++) begin
            if (fq[i].size() != 0) begin
                head        = fq[i][0];
                iReqVld[i]  = 1'b1;
                iReqDat[i]  = head[WIDTH-1:0];
                iReqLast[i] = head[WIDTH];
            end else begin
                iReqVld[i]  = 1'b0;
                iReqDat[i]  = '0;
                iReqLast[i] = 1'b0;
            end
        end
        ret     = (ret_mode == 2) ? m_link_vld : (ret_mode == 1);
        iCrdRet = ret;

        @(negedge clk);
        pop   = 0;
        found = 0;
        pidx  = 0;
        plast = 0;
        if (m_state == 0) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                int c;
                c = (m_rr + k) % NUM_REQ;
                if (!found && fq[c].size() != 0) begin
                    found = 1;
                    pidx  = c;
                end
            end
            pop = found && (m_crd != 0);
        end else begin
            pidx = m_owner;
            pop  = (fq[m_owner].size() != 0) && (m_crd != 0);
        end
        exp_rd = '0;
        if (pop) begin
            exp_rd[pidx] = 1'b1;
            head  = fq[pidx][0];
            plast = head[WIDTH];
        end

        check_eq("req_rd", 32'(oReqRd), 32'(exp_rd));
        last_rd   = oReqRd;
        last_busy = oBusy;
        last_vld  = oLinkVld;
        if (oReqRd != '0) dut_pops++;

        check_eq("link_vld", 32'(oLinkVld), 32'(m_link_vld));
        if (m_link_vld) begin
            check_eq("sb_avail", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                item   = sb.pop_front();
                m_dat  = item[WIDTH-1:0];
                m_last = item[WIDTH];
            end
        end
        check_eq("link_dat", oLinkDat, m_dat);
        check_eq("link_last", 32'(oLinkLast), 32'(m_last));
        check_eq("busy", 32'(oBusy), 32'(m_state == 1));
        check_eq("crd_ovf", 32'(oCrdOvf), 32'(m_ovf));
`ifdef PTRING_ARB_STATS_EN
        for (int i = 0; i < NUM_REQ; i++) begin
            check_eq("grant_cnt", 32'(oGrantCnt[i]), 32'(m_gcnt[i]));
        end
`endif

        if (pop) begin
            if (m_state == 0) begin
                if (plast) m_rr = (pidx + 1) % NUM_REQ;
                else begin
                    m_state = 1;
                    m_owner = pidx;
                end
            end else if (plast) begin
                m_state = 0;
                m_rr    = (m_owner + 1) % NUM_REQ;
            end
            if (plast && m_gcnt[pidx] < 65535) m_gcnt[pidx]++;
            sb.push_back(fq[pidx].pop_front());
        end
        if (pop && !ret) m_crd--;
        else if (!pop && ret) begin
            if (m_crd == CREDITS) m_ovf = 1;
            else m_crd++;
        end
        m_link_vld = pop;

        @(posedge clk);
        #1;
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;

        // Round-robin of three single-flit packets
        do_reset();
        push_pkt(0, 1); push_pkt(1, 1); push_pkt(2, 1);
        step(2); check_eq("t1_rd0", 32'(last_rd), 32'b001); check_eq("t1_vld0", 32'(last_vld), 32'd0);
        step(2); check_eq("t1_rd1", 32'(last_rd), 32'b010); check_eq("t1_vld1", 32'(last_vld), 32'd1);
        step(2); check_eq("t1_rd2", 32'(last_rd), 32'b100); check_eq("t1_vld2", 32'(last_vld), 32'd1);
        step(2); check_eq("t1_rd3", 32'(last_rd), 32'b000); check_eq("t1_vld3", 32'(last_vld), 32'd1);
        step(2); check_eq("t1_vld4", 32'(last_vld), 32'd0);

        // Multi-flit packet holds the link against a competing requester
        do_reset();
        push_pkt(1, 3);
        step(2); check_eq("t2_rd0", 32'(last_rd), 32'b010); check_eq("t2_busy0", 32'(last_busy), 32'd0);
        push_pkt(0, 1);
        step(2); check_eq("t2_rd1", 32'(last_rd), 32'b010); check_eq("t2_busy1", 32'(last_busy), 32'd1);
        step(2); check_eq("t2_rd2", 32'(last_rd), 32'b010); check_eq("t2_busy2", 32'(last_busy), 32'd1);
        step(2); check_eq("t2_rd3", 32'(last_rd), 32'b001); check_eq("t2_busy3", 32'(last_busy), 32'd0);
        repeat (2) step(2);

        // Bubble: owner empties mid-packet, others stay blocked
        push_flit(2, 0);
        step(2); check_eq("bub_rd0", 32'(last_rd), 32'b100);
        push_pkt(0, 1);
        step(2); check_eq("bub_rd1", 32'(last_rd), 32'b000);
        step(2); check_eq("bub_rd2", 32'(last_rd), 32'b000); check_eq("bub_busy", 32'(last_busy), 32'd1);
        push_flit(2, 1);
        step(2); check_eq("bub_rd3", 32'(last_rd), 32'b100);
        step(2); check_eq("bub_rd4", 32'(last_rd), 32'b001);
        repeat (2) step(2);

        // Credit exhaustion and single return
        do_reset();
        push_pkt(0, 1); push_pkt(0, 1); push_pkt(1, 1); push_pkt(1, 1);
        dut_pops = 0;
        repeat (6) step(0);
        check_eq("t3_pops_no_crd", 32'(dut_pops), 32'd2);
        step(1); check_eq("t3_rd_ret_cycle", 32'(last_rd), 32'b000);
        dut_pops = 0;
        step(0); check_eq("t3_pop_after_ret", 32'(dut_pops), 32'd1);
        repeat (2) step(0);
        check_eq("t3_pops_after_ret", 32'(dut_pops), 32'd1);

        // Simultaneous pop/return and credit overflow
        do_reset();
        push_pkt(0, 1); step(0);
        push_pkt(0, 1); step(1); check_eq("t4_rd_popret", 32'(last_rd), 32'b001);
        push_pkt(0, 1); step(0); check_eq("t4_rd_last_crd", 32'(last_rd), 32'b001);
        push_pkt(0, 1); step(0); check_eq("t4_rd_no_crd", 32'(last_rd), 32'b000);
        step(1); step(0);
        step(1); step(1);
        check_eq("t4_ovf_before", 32'(oCrdOvf), 32'd0);
        step(1);
        check_eq("t4_ovf_set", 32'(oCrdOvf), 32'd1);
        repeat (3) step(0);
        check_eq("t4_ovf_sticky", 32'(oCrdOvf), 32'd1);

        // Reset while locked on req2
        do_reset();
        push_pkt(2, 3);
        step(2); step(2);
        check_eq("t5_busy_pre", 32'(oBusy), 32'd1);
        push_pkt(0, 1);
        do_reset();
        push_pkt(0, 1); push_pkt(2, 1);
        step(2); check_eq("t5_rd_first", 32'(last_rd), 32'b001);
        repeat (3) step(2);

        // Random traffic against the model
        do_reset();
        for (int n = 0; n < 400; n++) begin
            for (int r = 0; r < NUM_REQ; r++) begin
                if (fq[r].size() < 3 && $urandom_range(0, 2) == 0) begin
                    push_pkt(r, int'($urandom_range(1, 3)));
                end
            end
            step(2);
        end

`ifdef PTRING_ARB_STATS_EN
        do_reset();
        for (int n = 0; n < 5; n++) begin
            push_pkt(1, 1);
            step(2);
        end
        step(2);
        check_eq("t6_cnt0", 32'(oGrantCnt[0]), 32'd0);
        check_eq("t6_cnt1", 32'(oGrantCnt[1]), 32'd5);
        check_eq("t6_cnt2", 32'(oGrantCnt[2]), 32'd0);
        for (int n = 0; n < 65535; n++) begin
            push_pkt(1, 1);
            step(2);
        end
        step(2);
        check_eq("t6_sat", 32'(oGrantCnt[1]), 32'h0000_FFFF);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
